// File: rtl/ham_pkg.sv
// Shared widths and FSM state encoding for the Hamming(7,4) decode front-end.
package ham_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/ham_decoder.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// Bit i of r is codeword position i+1 (parity at positions 1, 2, 4).
module ham_decoder
  import ham_pkg::*;
(
  input  logic [CODE_W-1:0] r,
  output logic [DATA_W-1:0] c,
  output logic [SYN_W-1:0]  p
);

  logic [2:0]        s;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    s[0]  = r[0] ^ r[2] ^ r[4] ^ r[6];
    s[1]  = r[1] ^ r[2] ^ r[5] ^ r[6];
    s[2]  = r[3] ^ r[4] ^ r[5] ^ r[6];
    fixed = r;
    // Nonzero syndrome names the 1-based position of the flipped bit.
    if (s != 3'd0) begin
      fixed[3'(s - 3'd1)] = ~r[3'(s - 3'd1)];
    end
    c = {fixed[6], fixed[5], fixed[4], fixed[2]};
    p = SYN_W'(s);
  end

endmodule

// File: rtl/ham_rr_arb.sv
// Combinational round-robin arbiter: first valid requester above ptr, with wrap.
module ham_rr_arb #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic              found;
  int unsigned       cand;
  logic [IDX_W-1:0]  cand_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ham_decode_ctrl.sv
// Arbitrated valid/ready front-end sharing one ham_decoder among N_REQ requesters.
// Define HAM_CTRL_STATS_EN to build the saturating corrected-error counter.
module ham_decode_ctrl
  import ham_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [CODE_W*N_REQ-1:0]    req_code,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic [DATA_W-1:0]          out_data,
  output logic [SYN_W-1:0]           out_syn,
  output logic                       out_err,
  input  logic                       clr_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [IDX_W-1:0]    id_q, id_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_id_q, out_id_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SYN_W-1:0]    out_syn_q, out_syn_d;
  logic                out_err_q, out_err_d;

  logic [N_REQ-1:0]    gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                accept;
  logic [DATA_W-1:0]   dec_c;
  logic [SYN_W-1:0]    dec_p;
  logic [CODE_W-1:0]   codes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign codes[i] = req_code[i*CODE_W +: CODE_W];
  end

  ham_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx)
  );

  ham_decoder u_dec (
    .r (code_q),
    .c (dec_c),
    .p (dec_p)
  );

  // Only IDLE offers a grant, so at most one codeword is ever in flight.
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    out_syn_d   = out_syn_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          code_d  = codes[gnt_idx];
          id_d    = gnt_idx;
          state_d = DECODE;
        end
      end
      DECODE: begin
        out_data_d  = dec_c;
        out_syn_d   = dec_p;
        out_err_d   = |dec_p;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset pointer to the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      id_q        <= '0;
      ptr_q       <= IDX_W'(N_REQ - 1);
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_syn_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      out_syn_q   <= out_syn_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign out_syn   = out_syn_q;
  assign out_err   = out_err_q;

`ifdef HAM_CTRL_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident increment; count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && out_err_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic stats_unused;
  assign stats_unused = clr_cnt;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_ham_decode_ctrl.sv
// Scoreboard bench for ham_decode_ctrl: directed stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_ham_decode_ctrl;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [6:0]  CODE_A = 7'b1100110;
  localparam logic [6:0]  CODE_B = 7'b1110110;

`ifdef HAM_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [0:0] id;
    logic [3:0] data;
    logic [3:0] syn;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_valid;
  logic [6:0]       code0, code1;
  logic [13:0]      req_code;
  logic [N_REQ-1:0] req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [0:0]       out_id;
  logic [3:0]       out_data;
  logic [3:0]       out_syn;
  logic             out_err;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  assign req_code = {code1, code0};

  always #5 clk = ~clk;

  ham_decode_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_err   (out_err),
    .clr_cnt   (clr_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
  endtask

  // Clean A and single-error B both decode to data 4'hD; B has syndrome 5.
  function automatic exp_t mk(input logic [0:0] id, input logic err);
    exp_t e;
    e.id   = id;
    e.data = 4'hD;
    e.syn  = err ? 4'h5 : 4'h0;
    e.err  = err;
    return e;
  endfunction

  // Monitor: err_cnt model, req_ready exclusivity and scoreboard pops.
  initial begin
    exp_t e;
    logic prev_acc;
    logic hs_err;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt  = 0;
        prev_acc = 1'b0;
      end else begin
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (out_valid || prev_acc) check("ready_busy", 32'(req_ready), 32'd0);
        hs_err = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_id",   32'(out_id),   32'(e.id));
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_syn",  32'(out_syn),  32'(e.syn));
            check("out_err",  32'(out_err),  32'(e.err));
            hs_err = e.err;
          end
        end
        if (STATS) begin
          if (clr_cnt) exp_cnt = 0;
          else if (hs_err && exp_cnt != 3) exp_cnt++;
        end
        prev_acc = |(req_valid & req_ready);
      end
    end
  end

  task automatic wait_accept(input logic [0:0] id);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [0:0] id, input logic [6:0] code, input logic err);
    exp_q.push_back(mk(id, err));
    if (id == 1'b0) code0 = code;
    else code1 = code;
    req_valid[id] = 1'b1;
    wait_accept(id);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n_acc;
    bit got;
    rst_n     = 1'b0;
    req_valid = '0;
    code0     = '0;
    code1     = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_id",    32'(out_id),    32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_syn",   32'(out_syn),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean word from requester 0, with accept-to-valid timing.
    send(1'b0, CODE_A, 1'b0);
    @(negedge clk);
    check("lat_decode_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_cycle", 32'(out_valid), 32'd1);
    drain();

    // Single-bit error from requester 1.
    send(1'b1, CODE_B, 1'b1);
    drain();
    @(negedge clk);
    check("err_cnt_after_err", 32'(err_cnt), STATS ? 32'd1 : 32'd0);
    @(posedge clk); #1;

    // Contention: both valid for six grants, expect alternating ids.
    code0 = CODE_A;
    code1 = CODE_B;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(1'(i % 2), (i % 2) == 1));
    req_valid = 2'b11;
    n_acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) n_acc++;
      if (n_acc == 6) break;
    end
    check("contention_accepts", 32'(n_acc), 32'd6);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Saturation: clear, then five errored results read 1,2,3,3,3.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, CODE_B, 1'b1);
      drain();
      @(negedge clk);
      check("err_cnt_sat", 32'(err_cnt), STATS ? 32'((k > 3) ? 3 : k) : 32'd0);
      @(posedge clk); #1;
    end

    // Backpressure on an errored result, then release together with clr_cnt.
    out_ready = 1'b0;
    send(1'b1, CODE_B, 1'b1);
    exp_q.push_back(mk(1'b0, 1'b0));
    code0 = CODE_A;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_id",    32'(out_id),    32'd1);
      check("bp_out_data",  32'(out_data),  32'hD);
      check("bp_out_syn",   32'(out_syn),   32'h5);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("bp_released", 32'(out_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'd1);
    check("clr_wins", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Async reset while a codeword sits in DECODE.
    send(1'b0, CODE_B, 1'b1);
    drain();
    exp_q.push_back(mk(1'b0, 1'b0));
    code0 = CODE_A;
    req_valid[0] = 1'b1;
    wait_accept(1'b0);
    req_valid = '0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid",   32'(out_valid), 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    code1 = CODE_B;
    req_valid = 2'b11;
    @(negedge clk);
    check("rr_after_reset", 32'(req_ready), 32'd1);
    exp_q.push_back(mk(1'b0, 1'b0));
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
